// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: mode codes, FSM states, field widths.
package counter_seq_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_RELOAD   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_PINGPONG = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Host-side command/status bundle of the counter sequencer.
interface counter_sequencer_if
  import counter_seq_pkg::*;
#(
  parameter int unsigned W = 8
);
  logic              start;
  logic              stop;
  logic              en;
  logic [W-1:0]      start_val;
  logic [W-1:0]      end_val;
  logic              up;
  logic [MODE_W-1:0] mode;
  logic [W-1:0]      count;
  logic              dir;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, en, start_val, end_val, up, mode,
    input  count, dir, busy, done
  );

  modport slave (
    input  start, stop, en, start_val, end_val, up, mode,
    output count, dir, busy, done
  );
endinterface

// File: rtl/counter_step_core.sv
// Registered up/down count with parallel load and terminal-value compare.
module counter_step_core #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         is_term
);

  // Load wins over a step; stepping wraps modulo 2^W.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + W'(1) : count - W'(1);
    end
  end

  assign is_term = (count == term_val);

endmodule

// File: rtl/counter_sequencer.sv
// Sequences a count register from a single start command: stepping, terminal handling
// (stop / reload / reverse) and busy/done reporting back to the host.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst,
  counter_sequencer_if.slave  bus
);

  state_t            state, state_n;
  logic [W-1:0]      cfg_start, cfg_start_n;
  logic [W-1:0]      cfg_end, cfg_end_n;
  logic              cfg_up, cfg_up_n;
  logic [MODE_W-1:0] cfg_mode, cfg_mode_n;
  logic              term_swap, term_swap_n;
  logic              dir, dir_n;
  logic              busy;
  logic              done, done_n;

  logic              core_load;
  logic [W-1:0]      core_load_val;
  logic              core_en;
  logic              core_up;
  logic [W-1:0]      term_val;
  logic              is_term;
  logic [W-1:0]      count;

  // In PINGPONG the start value becomes the terminal after each turnaround.
  assign term_val = term_swap ? cfg_start : cfg_end;

  counter_step_core #(.W(W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (core_load_val),
    .en       (core_en),
    .up       (core_up),
    .term_val (term_val),
    .count    (count),
    .is_term  (is_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cfg_start <= '0;
      cfg_end   <= '0;
      cfg_up    <= 1'b0;
      cfg_mode  <= '0;
      term_swap <= 1'b0;
      dir       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cfg_start <= cfg_start_n;
      cfg_end   <= cfg_end_n;
      cfg_up    <= cfg_up_n;
      cfg_mode  <= cfg_mode_n;
      term_swap <= term_swap_n;
      dir       <= dir_n;
      busy      <= (state_n == ST_RUN);
      done      <= done_n;
    end
  end

  // Next-state and step control; priority stop > start > en.
  always_comb begin
    state_n       = state;
    cfg_start_n   = cfg_start;
    cfg_end_n     = cfg_end;
    cfg_up_n      = cfg_up;
    cfg_mode_n    = cfg_mode;
    term_swap_n   = term_swap;
    dir_n         = dir;
    done_n        = 1'b0;
    core_load     = 1'b0;
    core_load_val = cfg_start;
    core_en       = 1'b0;
    core_up       = dir;

    if (bus.stop) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            cfg_start_n   = bus.start_val;
            cfg_end_n     = bus.end_val;
            cfg_up_n      = bus.up;
            cfg_mode_n    = bus.mode;
            term_swap_n   = 1'b0;
            dir_n         = bus.up;
            core_load     = 1'b1;
            core_load_val = bus.start_val;
            state_n       = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.en) begin
            if (!is_term) begin
              core_en = 1'b1;
            end else begin
              done_n = 1'b1;
              case (cfg_mode)
                MODE_RELOAD: begin
                  core_load = 1'b1;
                  dir_n     = cfg_up;
                end
                MODE_PINGPONG: begin
                  dir_n       = ~dir;
                  term_swap_n = ~term_swap;
                  // A degenerate range has nowhere to move: hold and just flip.
                  core_en     = (cfg_start != cfg_end);
                  core_up     = ~dir;
                end
                default: state_n = ST_IDLE;
              endcase
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.count = count;
  assign bus.dir   = dir;
  assign bus.busy  = busy;
  assign bus.done  = done;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: per-cycle expectations queued and compared after each edge.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] count;
    logic         dir;
    logic         busy;
    logic         done;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  string test_name = "reset";

  counter_sequencer_if #(.W(W)) bus ();

  counter_sequencer #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, expected %0d (t=%0t)", test_name, tag, obs, exp, $time);
    end
  endtask

  task automatic cfg(input logic [W-1:0] sv, input logic [W-1:0] ev, input logic u,
                     input logic [MODE_W-1:0] m);
    bus.start_val = sv;
    bus.end_val   = ev;
    bus.up        = u;
    bus.mode      = m;
  endtask

  // Drive one cycle of commands, queue what must be visible after the edge, then compare.
  task automatic tick(input logic st, input logic sp, input logic e,
                      input logic [W-1:0] c, input logic d, input logic b, input logic dn);
    exp_t x;
    bus.start = st;
    bus.stop  = sp;
    bus.en    = e;
    x = '{count: c, dir: d, busy: b, done: dn};
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("count", 32'(bus.count), 32'(x.count));
    check("dir",   32'(bus.dir),   32'(x.dir));
    check("busy",  32'(bus.busy),  32'(x.busy));
    check("done",  32'(bus.done),  32'(x.done));
  endtask

  initial begin
    rst = 1'b1;
    cfg(8'd0, 8'd0, 1'b0, MODE_ONESHOT);
    tick(0, 0, 0, 8'd0, 1, 0, 0);
    rst = 1'b0;

    test_name = "oneshot_up";
    cfg(8'd5, 8'd8, 1'b1, MODE_ONESHOT);
    tick(1, 0, 1, 8'd5, 1, 1, 0);
    cfg(8'd77, 8'd77, 1'b0, MODE_RELOAD);
    tick(0, 0, 1, 8'd6, 1, 1, 0);
    tick(0, 0, 1, 8'd7, 1, 1, 0);
    tick(0, 0, 1, 8'd8, 1, 1, 0);
    tick(0, 0, 1, 8'd8, 1, 0, 1);

    test_name = "start_on_done";
    cfg(8'd40, 8'd38, 1'b0, MODE_ONESHOT);
    tick(1, 0, 1, 8'd40, 0, 1, 0);
    tick(0, 0, 1, 8'd39, 0, 1, 0);
    tick(0, 0, 1, 8'd38, 0, 1, 0);
    tick(0, 0, 1, 8'd38, 0, 0, 1);
    tick(0, 0, 1, 8'd38, 0, 0, 0);

    test_name = "oneshot_wrap";
    cfg(8'd254, 8'd1, 1'b1, MODE_ONESHOT);
    tick(1, 0, 0, 8'd254, 1, 1, 0);
    tick(0, 0, 1, 8'd255, 1, 1, 0);
    tick(0, 0, 1, 8'd0,   1, 1, 0);
    tick(0, 0, 1, 8'd1,   1, 1, 0);
    tick(0, 0, 1, 8'd1,   1, 0, 1);

    test_name = "reload_down";
    cfg(8'd3, 8'd0, 1'b0, MODE_RELOAD);
    tick(1, 0, 1, 8'd3, 0, 1, 0);
    tick(0, 0, 1, 8'd2, 0, 1, 0);
    tick(0, 0, 1, 8'd1, 0, 1, 0);
    tick(0, 0, 1, 8'd0, 0, 1, 0);
    tick(0, 0, 1, 8'd3, 0, 1, 1);
    tick(0, 0, 1, 8'd2, 0, 1, 0);
    tick(0, 0, 1, 8'd1, 0, 1, 0);
    tick(0, 0, 1, 8'd0, 0, 1, 0);
    tick(0, 0, 1, 8'd3, 0, 1, 1);
    tick(0, 1, 1, 8'd3, 0, 0, 0);

    test_name = "pingpong";
    cfg(8'd2, 8'd4, 1'b1, MODE_PINGPONG);
    tick(1, 0, 1, 8'd2, 1, 1, 0);
    tick(0, 0, 1, 8'd3, 1, 1, 0);
    tick(0, 0, 1, 8'd4, 1, 1, 0);
    tick(0, 0, 1, 8'd3, 0, 1, 1);
    tick(0, 0, 1, 8'd2, 0, 1, 0);
    tick(0, 0, 1, 8'd3, 1, 1, 1);
    tick(0, 0, 1, 8'd4, 1, 1, 0);
    tick(0, 0, 1, 8'd3, 0, 1, 1);
    tick(0, 1, 1, 8'd3, 0, 0, 0);

    test_name = "pingpong_equal";
    cfg(8'd6, 8'd6, 1'b1, MODE_PINGPONG);
    tick(1, 0, 1, 8'd6, 1, 1, 0);
    tick(0, 0, 1, 8'd6, 0, 1, 1);
    tick(0, 0, 0, 8'd6, 0, 1, 0);
    tick(0, 0, 1, 8'd6, 1, 1, 1);
    tick(0, 1, 0, 8'd6, 1, 0, 0);

    test_name = "oneshot_equal";
    cfg(8'd9, 8'd9, 1'b0, MODE_ONESHOT);
    tick(1, 0, 0, 8'd9, 0, 1, 0);
    tick(0, 0, 1, 8'd9, 0, 0, 1);

    test_name = "mode_reserved";
    cfg(8'd1, 8'd2, 1'b1, 2'd3);
    tick(1, 0, 0, 8'd1, 1, 1, 0);
    tick(0, 0, 1, 8'd2, 1, 1, 0);
    tick(0, 0, 1, 8'd2, 1, 0, 1);

    test_name = "en_gaps_stop";
    cfg(8'd10, 8'd20, 1'b1, MODE_ONESHOT);
    tick(1, 0, 1, 8'd10, 1, 1, 0);
    tick(0, 0, 0, 8'd10, 1, 1, 0);
    tick(0, 0, 1, 8'd11, 1, 1, 0);
    tick(0, 0, 0, 8'd11, 1, 1, 0);
    tick(0, 0, 1, 8'd12, 1, 1, 0);
    cfg(8'd99, 8'd100, 1'b0, MODE_RELOAD);
    tick(1, 0, 1, 8'd13, 1, 1, 0);
    tick(0, 1, 1, 8'd13, 1, 0, 0);
    tick(0, 0, 1, 8'd13, 1, 0, 0);

    test_name = "reset_midrun";
    cfg(8'd0, 8'd5, 1'b1, MODE_ONESHOT);
    tick(1, 0, 0, 8'd0, 1, 1, 0);
    tick(0, 0, 1, 8'd1, 1, 1, 0);
    tick(0, 0, 1, 8'd2, 1, 1, 0);
    rst = 1'b1;
    tick(0, 0, 1, 8'd0, 1, 0, 0);
    rst = 1'b0;
    cfg(8'd7, 8'd7, 1'b0, MODE_ONESHOT);
    tick(1, 0, 0, 8'd7, 0, 1, 0);
    rst = 1'b1;
    tick(0, 0, 1, 8'd0, 1, 0, 0);
    rst = 1'b0;

    test_name = "stop_beats_start";
    cfg(8'd50, 8'd60, 1'b0, MODE_RELOAD);
    tick(1, 1, 1, 8'd0, 1, 0, 0);
    tick(0, 0, 1, 8'd0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
